// File: rtl/l2_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 handshakes around the L2 port arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches' view.
interface l2_port_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_ready;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
        output i_rdata, i_ready, d_rdata, d_ready, l2_read, l2_write, l2_addr, l2_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, l2_read, l2_write, l2_addr, l2_wdata
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Grants the single L2 port to the I-cache or D-cache miss path for one whole transaction,
// round-robin on ties, with saturating grant and conflict counters.
module l2_port_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    l2_port_arbiter_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] gnt_i_cnt,
    output logic [CNT_W-1:0] gnt_d_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD, StRelease} state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d; // 1: the D-cache was served last

    logic              req_i, req_d;
    logic              l2_read, l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
    logic              i_ready, d_ready;
    logic              inc_conflict;
    logic [CNT_W-1:0]  gnt_i_cnt_q, gnt_d_cnt_q, conflict_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_addr      = '0;
        l2_wdata     = '0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        i_rdata      = i_rdata_q;
        d_rdata      = d_rdata_q;
        inc_conflict = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_i && req_d) begin
                    inc_conflict = 1'b1;
                    state_d      = last_grant_q ? StGntI : StGntD;
                end else if (req_i) begin
                    state_d = StGntI;
                end else if (req_d) begin
                    state_d = StGntD;
                end
            end
            StGntI: begin
                l2_read = bus.i_read;
                l2_addr = bus.i_addr;
                if (bus.l2_ready) begin
                    i_ready      = 1'b1;
                    i_rdata      = bus.l2_rdata;
                    last_grant_d = 1'b0;
                    state_d      = StRelease;
                end
            end
            StGntD: begin
                // A simultaneous read and write is issued as the write.
                l2_read  = bus.d_read & ~bus.d_write;
                l2_write = bus.d_write;
                l2_addr  = bus.d_addr;
                l2_wdata = bus.d_wdata;
                if (bus.l2_ready) begin
                    d_ready      = 1'b1;
                    d_rdata      = bus.l2_rdata;
                    last_grant_d = 1'b1;
                    state_d      = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            gnt_i_cnt_q    <= '0;
            gnt_d_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (i_ready) begin
                i_rdata_q   <= bus.l2_rdata;
                gnt_i_cnt_q <= sat_inc(gnt_i_cnt_q);
            end
            if (d_ready) begin
                d_rdata_q   <= bus.l2_rdata;
                gnt_d_cnt_q <= sat_inc(gnt_d_cnt_q);
            end
            if (inc_conflict) begin
                conflict_cnt_q <= sat_inc(conflict_cnt_q);
            end
        end
    end

    assign bus.l2_read  = l2_read;
    assign bus.l2_write = l2_write;
    assign bus.l2_addr  = l2_addr;
    assign bus.l2_wdata = l2_wdata;
    assign bus.i_rdata  = i_rdata;
    assign bus.i_ready  = i_ready;
    assign bus.d_rdata  = d_rdata;
    assign bus.d_ready  = d_ready;

    assign busy         = (state_q != StIdle);
    assign gnt_i_cnt    = gnt_i_cnt_q;
    assign gnt_d_cnt    = gnt_d_cnt_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: table of single transactions plus hand sequences for ties,
// reset mid-transaction and a dropped request; completions are checked from a scoreboard.
module tb_l2_port_arbiter;
    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic [CNT_W-1:0] gnt_i_cnt, gnt_d_cnt, conflict_cnt;

    l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .gnt_i_cnt    (gnt_i_cnt),
        .gnt_d_cnt    (gnt_d_cnt),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] rdata;
    } exp_t;

    typedef struct {
        logic              ir;
        logic              dr;
        logic              dw;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] da;
        logic [LINE_W-1:0] wd;
        logic [LINE_W-1:0] rd;
        int                lat;
        logic              exp_d;
        logic              exp_rd;
        logic              exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_gi, exp_gd, exp_cf;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_gnt_i_cnt"}, LINE_W'(gnt_i_cnt), LINE_W'(exp_gi));
        check({tag, "_gnt_d_cnt"}, LINE_W'(gnt_d_cnt), LINE_W'(exp_gd));
        check({tag, "_conflict_cnt"}, LINE_W'(conflict_cnt), LINE_W'(exp_cf));
    endtask

    task automatic check_l2(input string tag, input logic rd, input logic wr,
                            input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
        check({tag, "_l2_read"}, LINE_W'(bus.l2_read), LINE_W'(rd));
        check({tag, "_l2_write"}, LINE_W'(bus.l2_write), LINE_W'(wr));
        check({tag, "_l2_addr"}, LINE_W'(bus.l2_addr), LINE_W'(addr));
        check({tag, "_l2_wdata"}, bus.l2_wdata, wdata);
    endtask

    // Waits lat cycles in the grant state, pulses l2_ready and drops the winner's request.
    task automatic finish_txn(input logic is_d, input logic [LINE_W-1:0] rd, input int lat);
        repeat (lat - 1) step();
        step();
        bus.l2_ready = 1'b1;
        bus.l2_rdata = rd;
        sb_q.push_back('{is_d, rd});
        @(negedge clk);
        step();
        bus.l2_ready = 1'b0;
        bus.l2_rdata = '0;
        if (is_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
            exp_gd      = sat(exp_gd);
        end else begin
            bus.i_read = 1'b0;
            exp_gi     = sat(exp_gi);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        step();
        bus.i_read  = v.ir;
        bus.i_addr  = v.ia;
        bus.d_read  = v.dr;
        bus.d_write = v.dw;
        bus.d_addr  = v.da;
        bus.d_wdata = v.wd;
        if (v.ir && (v.dr || v.dw)) exp_cf = sat(exp_cf);
        @(negedge clk);
        check_l2({tag, "_idle"}, 1'b0, 1'b0, '0, '0);
        step();
        @(negedge clk);
        check_l2({tag, "_gnt"}, v.exp_rd, v.exp_wr, v.exp_addr, v.exp_wdata);
        check({tag, "_busy_gnt"}, LINE_W'(busy), LINE_W'(1));
        check({tag, "_conflict"}, LINE_W'(conflict_cnt), LINE_W'(exp_cf));
        finish_txn(v.exp_d, v.rd, v.lat);
        bus.i_read  = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        @(negedge clk);
        check_l2({tag, "_release"}, 1'b0, 1'b0, '0, '0);
        check({tag, "_busy_release"}, LINE_W'(busy), LINE_W'(1));
        check({tag, "_rdata_hold"}, v.exp_d ? bus.d_rdata : bus.i_rdata, v.rd);
        check_counts(tag);
        step();
        @(negedge clk);
        check({tag, "_busy_idle"}, LINE_W'(busy), LINE_W'(0));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.i_ready || bus.d_ready) begin
            check("ready_onehot", LINE_W'(bus.i_ready & bus.d_ready), '0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b, expected none",
                         bus.i_ready, bus.d_ready);
            end else begin
                e = sb_q.pop_front();
                check("ready_port", LINE_W'(bus.d_ready), LINE_W'(e.is_d));
                check("ready_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        bus.i_read   = 1'b0;
        bus.i_addr   = '0;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.l2_rdata = '0;
        bus.l2_ready = 1'b0;
        exp_gi = 0;
        exp_gd = 0;
        exp_cf = 0;

        // ir dr dw  ia  da  wd  rd  lat | d  rd wr addr wdata ; last grant starts at I
        vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h10, 28'h0, 128'h0, 128'hA5, 3,
                    1'b0, 1'b1, 1'b0, 28'h10, 128'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h20, 128'h1234, 128'h0B, 2,
                    1'b1, 1'b0, 1'b1, 28'h20, 128'h1234};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h30, 128'hBEEF, 128'h77, 1,
                    1'b1, 1'b0, 1'b1, 28'h30, 128'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 28'h40, 28'h44, 128'h5555, 128'hC0DE, 2,
                    1'b0, 1'b1, 1'b0, 28'h40, 128'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h50, 28'h54, 128'h66, 128'h99, 1,
                    1'b1, 1'b1, 1'b0, 28'h54, 128'h66};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h60, 128'hF00, 128'hABC, 4,
                    1'b1, 1'b1, 1'b0, 28'h60, 128'hF00};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 28'h70, 28'h0, 128'h0, 128'hDEF, 2,
                    1'b0, 1'b1, 1'b0, 28'h70, 128'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 28'h80, 28'h0, 128'h0, 128'h111, 1,
                    1'b0, 1'b1, 1'b0, 28'h80, 128'h0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 28'h90, 28'h0, 128'h0, 128'h222, 1,
                    1'b0, 1'b1, 1'b0, 28'h90, 128'h0};

        #1;
        check_l2("por", 1'b0, 1'b0, '0, '0);
        check("por_busy", LINE_W'(busy), '0);
        check("por_i_rdata", bus.i_rdata, '0);
        check_counts("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // Reset while GNT_D is waiting on the L2.
        step();
        bus.d_read = 1'b1;
        bus.d_addr = 28'hABC;
        @(negedge clk);
        step();
        @(negedge clk);
        check("rst_pre_l2_read", LINE_W'(bus.l2_read), LINE_W'(1));
        #1 rst = 1'b0;
        #1 bus.l2_ready = 1'b1;
        bus.l2_rdata = 128'hDEAD;
        exp_gi = 0;
        exp_gd = 0;
        exp_cf = 0;
        #1;
        check_l2("rst_async", 1'b0, 1'b0, '0, '0);
        check("rst_async_d_ready", LINE_W'(bus.d_ready), '0);
        check("rst_async_busy", LINE_W'(busy), '0);
        check("rst_async_d_rdata", bus.d_rdata, '0);
        check("rst_async_i_rdata", bus.i_rdata, '0);
        check_counts("rst_async");
        @(negedge clk);
        check("rst_held_d_ready", LINE_W'(bus.d_ready), '0);
        check("rst_held_busy", LINE_W'(busy), '0);
        bus.l2_ready = 1'b0;
        bus.l2_rdata = '0;
        bus.d_read   = 1'b0;
        rst          = 1'b1;

        // Ties from reset: D wins, the held I request follows, and grants alternate.
        for (int r = 0; r < 2; r++) begin
            step();
            bus.i_read = 1'b1;
            bus.i_addr = ADDR_W'(32'h100 + r);
            bus.d_read = 1'b1;
            bus.d_addr = ADDR_W'(32'h200 + r);
            exp_cf     = sat(exp_cf);
            @(negedge clk);
            check_l2($sformatf("tie%0d_idle", r), 1'b0, 1'b0, '0, '0);
            step();
            @(negedge clk);
            check_l2($sformatf("tie%0d_gnt_d", r), 1'b1, 1'b0, ADDR_W'(32'h200 + r), '0);
            check($sformatf("tie%0d_conflict", r), LINE_W'(conflict_cnt), LINE_W'(exp_cf));
            finish_txn(1'b1, LINE_W'(32'h3000 + r), 2);
            @(negedge clk);
            check_l2($sformatf("tie%0d_release", r), 1'b0, 1'b0, '0, '0);
            step();
            @(negedge clk);
            check_l2($sformatf("tie%0d_idle_gap", r), 1'b0, 1'b0, '0, '0);
            step();
            @(negedge clk);
            check_l2($sformatf("tie%0d_gnt_i", r), 1'b1, 1'b0, ADDR_W'(32'h100 + r), '0);
            check($sformatf("tie%0d_no_extra_conflict", r), LINE_W'(conflict_cnt),
                  LINE_W'(exp_cf));
            finish_txn(1'b0, LINE_W'(32'h4000 + r), 1);
            @(negedge clk);
            step();
        end
        check_counts("ties");

        // Granted I-cache drops its request; D-side activity must be ignored meanwhile.
        step();
        bus.i_read = 1'b1;
        bus.i_addr = 28'h500;
        @(negedge clk);
        step();
        @(negedge clk);
        check_l2("drop_gnt", 1'b1, 1'b0, 28'h500, '0);
        step();
        bus.i_read  = 1'b0;
        bus.d_write = 1'b1;
        bus.d_addr  = 28'h600;
        bus.d_wdata = 128'h6666;
        @(negedge clk);
        check_l2("drop_low", 1'b0, 1'b0, 28'h500, '0);
        check("drop_busy", LINE_W'(busy), LINE_W'(1));
        check("drop_d_ready", LINE_W'(bus.d_ready), '0);
        step();
        bus.i_read = 1'b1;
        @(negedge clk);
        check_l2("drop_back", 1'b1, 1'b0, 28'h500, '0);
        finish_txn(1'b0, 128'h777, 1);
        bus.d_write = 1'b0;
        @(negedge clk);
        check_l2("drop_release", 1'b0, 1'b0, '0, '0);
        check_counts("drop");
        step();
        @(negedge clk);
        check("drop_busy_idle", LINE_W'(busy), '0);

        check("sb_empty", LINE_W'(sb_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
